// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the ROM and the
// arbiter. The arbiter uses the slave view; the requesters/ROM side uses master.
interface rom_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic [31:0] rom_addr;
  logic        rom_re;
  logic [31:0] rom_out;
  logic        rom_oe;

  logic        stall;
  logic        err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, rom_out, rom_oe,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           rom_addr, rom_re, stall, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, rom_out, rom_oe,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           rom_addr, rom_re, stall, err
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding ROM.
// IDLE grants (combinationally) one requester, ISSUE strobes the ROM for one
// cycle, WAIT collects the data or times out with an error response.
module rom_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic               clk,
  input logic               reset_n,
  rom_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_last_ls;   // 1: load/store was granted last (fetch wins next tie)
  logic        r_sel_ls;    // identity of the port owning the transaction
  logic [7:0]  r_cnt;
  logic [31:0] r_rom_addr;
  logic        r_rom_re;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;
  logic        r_if_rvalid;
  logic        r_ls_rvalid;
  logic        r_err;

  logic        w_idle;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic [31:0] w_gnt_word;
  logic        w_tmo;
  logic        w_resp;
  logic [31:0] w_resp_data;

  // Grant decode, response qualification and timeout detection
  always_comb begin
    // reset_n gates the grants so gnt stays low while reset is held
    w_idle      = reset_n && (r_state == IDLE);
    w_if_gnt    = w_idle && bus.if_req && (!bus.ls_req || r_last_ls);
    w_ls_gnt    = w_idle && bus.ls_req && !w_if_gnt;
    w_gnt_word  = (w_ls_gnt ? bus.ls_addr : bus.if_addr) & 32'hFFFF_FFFC;
    w_tmo       = (r_cnt + 8'd1) == TMO;
    // rom_oe outranks a timeout landing in the same cycle
    w_resp      = (r_state == WAIT) && (bus.rom_oe || w_tmo);
    w_resp_data = bus.rom_oe ? bus.rom_out : 32'h0;
  end

  // Main FSM with registered ROM strobe/address and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_ls   <= 1'b1;
      r_sel_ls    <= 1'b0;
      r_cnt       <= 8'd0;
      r_rom_addr  <= 32'h0;
      r_rom_re    <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_ls_rdata  <= 32'h0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rom_re    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_if_gnt || w_ls_gnt) begin
            // rom_addr doubles as the latched request address; loading it at
            // grant time makes it valid together with rom_re during ISSUE
            r_sel_ls   <= w_ls_gnt;
            r_last_ls  <= w_ls_gnt;
            r_rom_addr <= w_gnt_word;
            r_rom_re   <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (!bus.rom_oe) r_cnt <= r_cnt + 8'd1;
          if (w_resp) begin
            if (r_sel_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= w_resp_data;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= w_resp_data;
            end
            r_err   <= !bus.rom_oe;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_re    = r_rom_re;
  assign bus.stall     = (r_state != IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: per-cycle comparison against a transaction-level
// timeline model (grant cycle -> strobe, response and stall cycles computed
// from the ROM latency chosen by the bench).
module tb_rom_port_arbiter;
  localparam int TO = 4;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rom_port_arbiter_if bus();

  rom_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_at = 0;
  int quiet_until = -1;
  bit m_last_ls = 1'b1;

  bit          e_re   [NC];
  logic [31:0] e_addr [NC];
  bit          e_vif  [NC];
  bit          e_vls  [NC];
  bit          e_err  [NC];
  bit          e_stall[NC];
  logic [31:0] e_data [NC];
  bit          oe_drv [NC];
  logic [31:0] oe_dat [NC];

  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_rd_if = 32'h0;
  logic [31:0] m_rd_ls = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_if_gnt"},    bus.if_gnt,    0);
    chk({tag, "_ls_gnt"},    bus.ls_gnt,    0);
    chk({tag, "_rom_re"},    bus.rom_re,    0);
    chk({tag, "_rom_addr"},  bus.rom_addr,  0);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    chk({tag, "_ls_rvalid"}, bus.ls_rvalid, 0);
    chk({tag, "_if_rdata"},  bus.if_rdata,  0);
    chk({tag, "_ls_rdata"},  bus.ls_rdata,  0);
    chk({tag, "_stall"},     bus.stall,     0);
    chk({tag, "_err"},       bus.err,       0);
  endtask

  // One cycle: drive inputs, apply model for a grant, compare all outputs.
  // lat = ROM latency (cycles after rom_re) used if this cycle grants.
  task automatic step(input bit ir, input logic [31:0] ia,
                      input bit lr, input logic [31:0] la, input int lat);
    bit gi, gl;
    int resp;
    logic [31:0] d;
    if (cyc <= quiet_until) begin ir = 0; lr = 0; end
    // stray rom_oe while the model says the arbiter is idle
    if (cyc >= free_at && !oe_drv[cyc] && $urandom_range(0, 3) == 0) begin
      oe_drv[cyc] = 1; oe_dat[cyc] = $urandom;
    end
    bus.if_req  = ir; bus.if_addr = ia;
    bus.ls_req  = lr; bus.ls_addr = la;
    bus.rom_oe  = oe_drv[cyc];
    bus.rom_out = oe_drv[cyc] ? oe_dat[cyc] : $urandom;
    #1;
    gi = 0; gl = 0;
    if (cyc >= free_at && (ir || lr)) begin
      if (ir && lr) begin gi = m_last_ls; gl = !m_last_ls; end
      else begin gi = ir; gl = lr; end
      m_last_ls = gl;
      e_re[cyc+1]   = 1;
      e_addr[cyc+1] = (gl ? la : ia) & 32'hFFFF_FFFC;
      if (lat <= TO) begin
        d = $urandom;
        oe_drv[cyc+1+lat] = 1; oe_dat[cyc+1+lat] = d;
        resp = cyc + 2 + lat;
      end else begin
        d = 32'h0;
        resp = cyc + 2 + TO;
        e_err[resp] = 1;
        // late response two cycles after the error; requests held off meanwhile
        oe_drv[resp+2] = 1; oe_dat[resp+2] = $urandom;
        quiet_until = resp + 2;
      end
      if (gl) e_vls[resp] = 1; else e_vif[resp] = 1;
      e_data[resp] = d;
      for (int k = cyc + 1; k < resp; k++) e_stall[k] = 1;
      free_at = resp;
      // stray rom_oe during the strobe cycle
      if ($urandom_range(0, 2) == 0) begin oe_drv[cyc+1] = 1; oe_dat[cyc+1] = $urandom; end
    end
    if (e_re[cyc])  m_addr  = e_addr[cyc];
    if (e_vif[cyc]) m_rd_if = e_data[cyc];
    if (e_vls[cyc]) m_rd_ls = e_data[cyc];
    chk("if_gnt",    bus.if_gnt,    gi);
    chk("ls_gnt",    bus.ls_gnt,    gl);
    chk("gnt_both",  bus.if_gnt & bus.ls_gnt, 0);
    chk("rom_re",    bus.rom_re,    e_re[cyc]);
    chk("rom_addr",  bus.rom_addr,  m_addr);
    chk("if_rvalid", bus.if_rvalid, e_vif[cyc]);
    chk("ls_rvalid", bus.ls_rvalid, e_vls[cyc]);
    chk("if_rdata",  bus.if_rdata,  m_rd_if);
    chk("ls_rdata",  bus.ls_rdata,  m_rd_ls);
    chk("err",       bus.err,       e_err[cyc]);
    chk("stall",     bus.stall,     e_stall[cyc]);
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, 0, $urandom, 1);
  endtask

  // Asynchronous reset asserted mid-cycle; model forgets everything in flight
  task automatic mid_reset();
    chk("pre_rst_stall", bus.stall, 1);
    bus.rom_oe = 0; bus.if_req = 1; bus.ls_req = 1;
    reset_n = 0;
    #1;
    check_zero("mrst");
    for (int k = cyc + 1; k < cyc + 64; k++) begin
      e_re[k] = 0; e_vif[k] = 0; e_vls[k] = 0; e_err[k] = 0; e_stall[k] = 0;
    end
    m_addr = 0; m_rd_if = 0; m_rd_ls = 0; m_last_ls = 1;
    @(posedge clk); cyc++; @(negedge clk);
    bus.if_req = 0; bus.ls_req = 0;
    reset_n = 1;
    free_at = cyc;
  endtask

  initial begin
    int gc;
    reset_n = 0;
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.ls_req = 0; bus.ls_addr = 32'h0;
    bus.rom_oe = 0; bus.rom_out = 32'h0;
    #12;
    check_zero("por");
    @(negedge clk); @(negedge clk);
    bus.if_req = 0;
    reset_n = 1;
    cyc = 0;

    // fetch only, latency 1
    step(1, 32'h0000_0104, 0, 0, 1);
    idle(4);
    // both requesting continuously: IF, LS, IF, LS
    repeat (13) step(1, $urandom, 1, $urandom, 1);
    idle(3);
    // unaligned load address
    step(0, 0, 1, 32'h0000_0203, 2);
    idle(5);
    // timeout, late rom_oe ignored, then normal service
    step(0, 0, 1, 32'h0000_0400, 7);
    idle(12);
    step(0, 0, 1, 32'h0000_0404, 1);
    idle(4);
    // rom_oe on the timeout cycle wins
    step(1, 32'h0000_0500, 0, 0, TO);
    idle(8);
    // reset in WAIT, late rom_oe, then a tie grants fetch
    gc = cyc;
    step(0, 0, 1, 32'h0000_0600, 6);
    idle(2);
    quiet_until = gc + 7;
    mid_reset();
    idle(6);
    step(1, $urandom, 1, $urandom, 1);
    idle(4);
    // randomized traffic
    repeat (800)
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(1, 6));
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
